// File: rtl/nois_system_led_driver.sv
// nois_system_led_driver: LED effect engine (PWM brightness, blink, chase, alternate) behind a small Avalon-MM slave.
module nois_system_led_driver #(
  parameter int TICK_DIV   = 50000,
  parameter int PERIOD_RST = 250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  pattern_in,
  output logic [7:0]  led_out
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  logic          en;
  logic [1:0]    mode;
  logic [7:0]    bright;
  logic [15:0]   period;
  logic [7:0]    pat_q;
  logic [PW-1:0] presc;
  logic [15:0]   step_cnt;
  logic [7:0]    pwm_cnt;
  logic          phase;
  logic [2:0]    chase_pos;
  logic          wr, restart, per_wr, tick, step, pwm_on;
  logic [15:0]   per_m1;
  logic [7:0]    rot, eff;
  assign wr      = chipselect & ~write_n;
  assign restart = wr && address == 2'd3;
  assign per_wr  = wr && address == 2'd2;
  assign tick    = en && presc == PMAX;
  assign per_m1  = (period == 16'd0) ? 16'd0 : period - 16'd1;
  assign step    = tick && step_cnt >= per_m1;
  assign pwm_on  = pwm_cnt < bright;
  assign rot     = (pat_q << chase_pos) | (pat_q >> (4'd8 - {1'b0, chase_pos}));
  assign eff     = mode == 2'b00 ? pat_q :
                   mode == 2'b01 ? pat_q & {8{phase}} :
                   mode == 2'b10 ? rot : pat_q ^ {8{phase}};
  assign readdata = address == 2'd0 ? {29'd0, mode, en} :
                    address == 2'd1 ? {24'd0, bright} :
                    address == 2'd2 ? {16'd0, period} :
                                      {21'd0, chase_pos, 7'd0, phase};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en     <= 1'b1;
      mode   <= 2'b00;
      bright <= 8'hFF;
      period <= 16'(PERIOD_RST);
    end else if (wr) begin
      if (address == 2'd0) {mode, en} <= writedata[2:0];
      if (address == 2'd1) bright <= writedata[7:0];
      if (address == 2'd2) period <= writedata[15:0];
    end
  end
  // Timebase and effect state; a RESTART beats any tick or step on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q     <= 8'h00;
      presc     <= '0;
      step_cnt  <= 16'd0;
      pwm_cnt   <= 8'd0;
      phase     <= 1'b0;
      chase_pos <= 3'd0;
      led_out   <= 8'h00;
    end else begin
      pat_q   <= pattern_in;
      led_out <= en ? (eff & {8{pwm_on}}) : 8'h00;
      if (!en || restart) begin
        presc     <= '0;
        step_cnt  <= 16'd0;
        pwm_cnt   <= 8'd0;
        phase     <= 1'b0;
        chase_pos <= 3'd0;
      end else begin
        presc    <= (presc == PMAX) ? '0 : presc + 1'b1;
        pwm_cnt  <= (pwm_cnt == 8'd254) ? 8'd0 : pwm_cnt + 8'd1;
        step_cnt <= (per_wr || step) ? 16'd0 : tick ? step_cnt + 16'd1 : step_cnt;
        if (step && !per_wr) begin
          phase     <= ~phase;
          chase_pos <= chase_pos + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_nois_system_led_driver.sv
// tb_nois_system_led_driver: directed checks of reset, blink, chase, PWM, restart priority, async reset and disable.
module tb_nois_system_led_driver;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  pattern_in = 8'h00;
  logic [7:0]  led_out;
  int checks = 0;
  int errors = 0;
  logic [7:0] chase_tbl [8] = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0};
  always #5 clk = ~clk;
  nois_system_led_driver #(.TICK_DIV(4), .PERIOD_RST(250)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pattern_in(pattern_in), .led_out(led_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask
  initial begin
    int on_cnt, off_cnt;
    pattern_in = 8'hA5;
    #12;
    check("led_in_reset", {24'd0, led_out}, 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("led_first_clk", {24'd0, led_out}, 32'h00);
    @(posedge clk); #1;
    check("led_second_clk", {24'd0, led_out}, 32'hA5);
    rd_check("rst_ctrl", 2'd0, 32'h1);
    rd_check("rst_bright", 2'd1, 32'hFF);
    rd_check("rst_period", 2'd2, 32'd250);
    // blink, PERIOD=2: one level per 8 clk
    pattern_in = 8'h0F;
    bus_wr(2'd2, 32'd2);
    bus_wr(2'd0, 32'h3);
    bus_wr(2'd3, 32'd0);
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      check("blink_led", {24'd0, led_out}, (((k - 1) / 8) % 2) ? 32'h0F : 32'h00);
      rd_check("blink_status", 2'd3, ((((k / 8) % 8)) << 8) | ((k / 8) % 2));
    end
    // chase, PERIOD=1: rotate every 4 clk, wrapping 7 -> 0
    pattern_in = 8'h81;
    bus_wr(2'd0, 32'h5);
    bus_wr(2'd2, 32'd1);
    bus_wr(2'd3, 32'd0);
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #1;
      check("chase_led", {24'd0, led_out}, {24'd0, chase_tbl[((k - 1) / 4) % 8]});
      rd_check("chase_status", 2'd3, (((k / 4) % 8) << 8) | ((k / 4) % 2));
    end
    // PWM duty
    pattern_in = 8'hFF;
    bus_wr(2'd0, 32'h1);
    bus_wr(2'd1, 32'h40);
    repeat (3) @(posedge clk);
    on_cnt = 0;
    off_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      @(posedge clk); #1;
      if (led_out == 8'hFF) on_cnt++;
      else if (led_out == 8'h00) off_cnt++;
    end
    check("pwm_on_cnt", on_cnt, 64);
    check("pwm_off_cnt", off_cnt, 191);
    bus_wr(2'd1, 32'h00);
    repeat (2) @(posedge clk);
    on_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      @(posedge clk); #1;
      if (led_out != 8'h00) on_cnt++;
    end
    check("pwm_zero_cnt", on_cnt, 0);
    bus_wr(2'd1, 32'hFF);
    // restart coinciding with a step (steps land 4 clk after restart at PERIOD=1)
    bus_wr(2'd0, 32'h3);
    bus_wr(2'd2, 32'd1);
    bus_wr(2'd3, 32'd0);
    repeat (3) @(posedge clk);
    bus_wr(2'd3, 32'd0);
    rd_check("restart_vs_step", 2'd3, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rd_check("restart_pre_step", 2'd3, 32'h0);
    @(posedge clk); #1;
    rd_check("restart_next_step", 2'd3, 32'h101);
    // PERIOD write coinciding with a step (PERIOD=2 steps land 8 clk after restart)
    bus_wr(2'd2, 32'd2);
    bus_wr(2'd3, 32'd0);
    repeat (7) @(posedge clk);
    bus_wr(2'd2, 32'd2);
    rd_check("period_wr_vs_step", 2'd3, 32'h0);
    repeat (7) @(posedge clk);
    #1;
    rd_check("period_wr_pre_step", 2'd3, 32'h0);
    @(posedge clk); #1;
    rd_check("period_wr_next_step", 2'd3, 32'h101);
    // async reset in the middle of a lit blink phase
    pattern_in = 8'h0F;
    bus_wr(2'd3, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("blink_lit", {24'd0, led_out}, 32'h0F);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_led", {24'd0, led_out}, 32'h00);
    rd_check("async_ctrl", 2'd0, 32'h1);
    rd_check("async_bright", 2'd1, 32'hFF);
    rd_check("async_period", 2'd2, 32'd250);
    rd_check("async_status", 2'd3, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    // disable
    pattern_in = 8'hA5;
    bus_wr(2'd2, 32'd1);
    repeat (21) @(posedge clk);
    #1;
    check("static_led", {24'd0, led_out}, 32'hA5);
    bus_wr(2'd0, 32'h0);
    @(posedge clk); #1;
    check("disable_led", {24'd0, led_out}, 32'h00);
    rd_check("disable_status", 2'd3, 32'h0);
    rd_check("disable_ctrl", 2'd0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
